vga_timing_gen: RTL and testbench

- Pixel-timing source for every sprite display stage.
- Generates 640x480@60 raster coordinates (DrawX, DrawY), the active-video flag (blank) and the sync pulses.
- Also provides a per-frame animation index that selects which attack-sprite frame ROM the downstream sprite drawers read.
- Runs entirely on vga_clk (25 MHz pixel clock). Its outputs feed the sprite/palette stages directly.

---
 rtl/vga_timing_gen.sv | 71 +++++++
 tb/tb_vga_timing_gen.sv | 114 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters, aligned sync/blank outputs and per-frame animation index
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int ANIM_DIV    = 8,
  parameter int ANIM_FRAMES = 4,
  parameter int ANIM_W      = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              anim_en,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic              frame_start,
  output logic [ANIM_W-1:0] anim_frame
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  logic [9:0]       hc_n, vc_n;
  logic             wrap_h, entry;
  logic [DIV_W-1:0] div;
  // Next raster position; every output is derived from it so all outputs stay aligned
  always_comb begin
    wrap_h = DrawX == 10'(H_TOTAL - 1);
    entry  = wrap_h && DrawY == 10'(V_TOTAL - 1);
    hc_n   = wrap_h ? 10'd0 : DrawX + 10'd1;
    vc_n   = wrap_h ? (DrawY == 10'(V_TOTAL - 1) ? 10'd0 : DrawY + 10'd1) : DrawY;
  end
  // Raster position and the sync/blank/frame flags describing that same position
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= 10'(H_TOTAL - 1);
      DrawY       <= 10'(V_TOTAL - 1);
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= hc_n;
      DrawY       <= vc_n;
      hs          <= !(hc_n >= 10'(H_ACTIVE + H_FP) && hc_n < 10'(H_ACTIVE + H_FP + H_SYNC));
      vs          <= !(vc_n >= 10'(V_ACTIVE + V_FP) && vc_n < 10'(V_ACTIVE + V_FP + V_SYNC));
      blank       <= hc_n < 10'(H_ACTIVE) && vc_n < 10'(V_ACTIVE);
      frame_start <= entry;
    end
  end
  // Animation divider steps only on frame entry, so anim_frame is constant across a frame
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      div        <= '0;
      anim_frame <= '0;
    end else if (entry && anim_en) begin
      if (div == DIV_W'(ANIM_DIV - 1)) begin
        div        <= '0;
        anim_frame <= anim_frame == ANIM_W'(ANIM_FRAMES - 1) ? '0 : anim_frame + ANIM_W'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized check of a default and a shrunk raster against an arithmetic position model
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HSW = 4, HB = 3, VA = 12, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB, VT = VA + VF + VSW + VB, FL_S = HT * VT;
  localparam int FL_D = 800 * 525;
  logic vga_clk = 1'b0, reset_n = 1'b0, anim_en = 1'b1;
  logic hs_d, vs_d, blank_d, fs_d, hs_s, vs_s, blank_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic [1:0] af_d, af_s;
  int checks = 0, passed = 0;
  int k = 0, n_d = 0, n_s = 0;
  logic checking = 1'b0;
  always #20 vga_clk = ~vga_clk;
  vga_timing_gen dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .anim_en(anim_en), .hs(hs_d), .vs(vs_d), .blank(blank_d),
    .DrawX(x_d), .DrawY(y_d), .frame_start(fs_d), .anim_frame(af_d)
  );
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .ANIM_DIV(2), .ANIM_FRAMES(4), .ANIM_W(2)
  ) dut_s (
    .vga_clk(vga_clk), .reset_n(reset_n), .anim_en(anim_en), .hs(hs_s), .vs(vs_s), .blank(blank_s),
    .DrawX(x_s), .DrawY(y_s), .frame_start(fs_s), .anim_frame(af_s)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", tag, obs, exp, $time);
  endtask
  function automatic logic [25:0] expv(input int ha, hf, hsw, hb, va, vf, vsw, vb, dv, nf, kk, n);
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    int x = ht - 1, y = vt - 1, p;
    if (kk != 0) begin
      p = (kk - 1) % (ht * vt);
      x = p % ht;
      y = p / ht;
    end
    return {10'(x), 10'(y), !(x >= ha + hf && x < ha + hf + hsw), !(y >= va + vf && y < va + vf + vsw),
            x < ha && y < va, kk != 0 && x == 0 && y == 0, 2'((n / dv) % nf)};
  endfunction
  function automatic logic [25:0] exp_d();
    return expv(640, 16, 96, 48, 480, 10, 2, 33, 8, 4, k, n_d);
  endfunction
  function automatic logic [25:0] exp_s();
    return expv(HA, HF, HSW, HB, VA, VF, VSW, VB, 2, 4, k, n_s);
  endfunction
  // k = edges since reset release; n_* = frame entries that saw anim_en high
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      k <= 0; n_d <= 0; n_s <= 0;
    end else begin
      k <= k + 1;
      if (k % FL_D == 0 && anim_en) n_d <= n_d + 1;
      if (k % FL_S == 0 && anim_en) n_s <= n_s + 1;
    end
  end
  always @(negedge vga_clk) begin
    if (checking) begin
      check("dflt", {x_d, y_d, hs_d, vs_d, blank_d, fs_d, af_d}, exp_d());
      check("small", {x_s, y_s, hs_s, vs_s, blank_s, fs_s, af_s}, exp_s());
    end
  end
  task automatic run(input int n);
    repeat (n) @(negedge vga_clk);
  endtask
  task automatic wait_fs(output int c, output int vl);
    c = 0; vl = 0;
    do begin
      @(negedge vga_clk);
      c++;
      if (!vs_s) vl++;
    end while (!fs_s && c < 2 * FL_S);
  endtask
  initial begin
    int c, vl, guard;
    checking = 1'b1;
    run(5);
    reset_n = 1'b1;
    run(9 * FL_S);
    anim_en = 1'b0;
    run(3 * FL_S);
    anim_en = 1'b1;
    run(2 * FL_S);
    wait_fs(c, vl);
    wait_fs(c, vl);
    check("fs_period", c, FL_S);
    check("vs_low", vl, VSW * HT);
    for (int i = 0; i < 6; i++) begin
      anim_en = 1'($urandom_range(0, 1));
      run($urandom_range(FL_S / 2, 2 * FL_S));
    end
    anim_en = 1'b1;
    guard = 0;
    while (((n_s / 2) % 4) != 2 && guard < 10) begin
      run(FL_S);
      guard++;
    end
    check("anim_reach2", af_s, 2'd2);
    run($urandom_range(30, FL_S - 30));
    reset_n = 1'b0;
    #1;
    check("rst_async_d", {x_d, y_d, hs_d, vs_d, blank_d, fs_d, af_d}, exp_d());
    check("rst_async_s", {x_s, y_s, hs_s, vs_s, blank_s, fs_s, af_s}, exp_s());
    run(3);
    reset_n = 1'b1;
    run(1);
    check("restart_pos", {x_s, y_s, fs_s, blank_s}, {10'd0, 10'd0, 1'b1, 1'b1});
    run(2 * FL_S);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
